// File: rtl/game_counter_pkg.sv
// game_counter_pkg: shared enums for the game counter (count modes and game result codes)
package game_counter_pkg;
  typedef enum logic [1:0] {
    UP_ONE   = 2'b00,
    UP_TWO   = 2'b01,
    DOWN_ONE = 2'b10,
    DOWN_TWO = 2'b11
  } ctrl_mode_e;
  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;
endpackage

// File: rtl/game_counter_tally.sv
// game_counter_tally: clearable event tally with a flag that looks at the post-increment value
// ports: clk, rst_l (async active-low), clr (sync clear, wins over inc), inc (+1),
//        limit_o (value being written this edge equals LIMIT)
module game_counter_tally #(
  parameter int W     = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  input  logic inc,
  output logic limit_o
);
  logic [W-1:0] tally_q, tally_d;
  always_comb begin
    tally_d = clr ? '0 : tally_q + W'(inc);
    limit_o = tally_d == W'(LIMIT);
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) tally_q <= '0;
    else        tally_q <= tally_d;
  end
endmodule

// File: rtl/game_counter.sv
// game_counter: up/down game counter with win/lose pulses, tallies and self-restarting game over
// ports: clk, rst_l (async active-low), ctrl (count mode), INIT/loadValue (sync load + clear),
//        LOSER/WINNER/GAMEOVER (registered pulses), WHO (result during game-over cycle),
//        count_o (only with GAME_COUNTER_COUNT_OUT_EN defined: mirrors the count)
module game_counter
  import game_counter_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int TALLY_LIMIT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [1:0]              ctrl,
  input  logic                    INIT,
  input  logic [COUNTER_SIZE-1:0] loadValue,
  output logic                    LOSER,
  output logic                    WINNER,
  output logic                    GAMEOVER,
  output logic [1:0]              WHO
`ifdef GAME_COUNTER_COUNT_OUT_EN
  ,
  output logic [COUNTER_SIZE-1:0] count_o
`endif
);
  ctrl_mode_e              mode;
  logic [COUNTER_SIZE-1:0] count_q, count_d, step;
  logic                    loser_q, loser_d, winner_q, winner_d, gameover_q, gameover_d;
  who_e                    who_q, who_d;
  logic                    clr, lose_inc, win_inc, lose_lim, win_lim;
  game_counter_tally #(.W(COUNTER_SIZE), .LIMIT(TALLY_LIMIT)) u_lose (
    .clk(clk), .rst_l(rst_l), .clr(clr), .inc(lose_inc), .limit_o(lose_lim)
  );
  game_counter_tally #(.W(COUNTER_SIZE), .LIMIT(TALLY_LIMIT)) u_win (
    .clk(clk), .rst_l(rst_l), .clr(clr), .inc(win_inc), .limit_o(win_lim)
  );
  // restart after game over and INIT both wipe the tallies and suppress events
  always_comb begin
    mode       = ctrl_mode_e'(ctrl);
    step       = COUNTER_SIZE'((mode inside {UP_TWO, DOWN_TWO}) ? 2 : 1);
    clr        = gameover_q | INIT;
    lose_inc   = !clr && count_q == '0;
    win_inc    = !clr && count_q == '1;
    count_d    = gameover_q ? '0 :
                 INIT ? loadValue :
                 (mode inside {DOWN_ONE, DOWN_TWO}) ? count_q - step : count_q + step;
    loser_d    = lose_inc;
    winner_d   = win_inc;
    gameover_d = !clr && (lose_lim || win_lim);
    who_d      = clr ? WHO_NONE : lose_lim ? WHO_LOSER : win_lim ? WHO_WINNER : WHO_NONE;
  end
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count_q    <= '0;
      loser_q    <= 1'b0;
      winner_q   <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else begin
      count_q    <= count_d;
      loser_q    <= loser_d;
      winner_q   <= winner_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end
  assign LOSER    = loser_q;
  assign WINNER   = winner_q;
  assign GAMEOVER = gameover_q;
  assign WHO      = who_q;
`ifdef GAME_COUNTER_COUNT_OUT_EN
  assign count_o  = count_q;
`endif
endmodule

// File: tb/tb_game_counter.sv
// tb_game_counter: scoreboard bench for game_counter (directed vectors, expected values queued per edge)
module tb_game_counter;
  logic       clk = 1'b0;
  logic       rst_l;
  logic [1:0] ctrl;
  logic       INIT;
  logic [3:0] loadValue;
  logic       LOSER, WINNER, GAMEOVER;
  logic [1:0] WHO;
`ifdef GAME_COUNTER_COUNT_OUT_EN
  logic [3:0] count_o;
`endif
  bit probe = 1'b0;
  typedef struct {
    int         id;
    logic       l;
    logic       w;
    logic       g;
    logic [1:0] who;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int   id = 0;
  int   tests = 0;
  int   fails = 0;
  game_counter #(.COUNTER_SIZE(4), .TALLY_LIMIT(15)) dut (
    .clk(clk), .rst_l(rst_l), .ctrl(ctrl), .INIT(INIT), .loadValue(loadValue),
    .LOSER(LOSER), .WINNER(WINNER), .GAMEOVER(GAMEOVER), .WHO(WHO)
`ifdef GAME_COUNTER_COUNT_OUT_EN
    , .count_o(count_o)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk or posedge probe) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({LOSER, WINNER, GAMEOVER, WHO} !== {e.l, e.w, e.g, e.who}) begin
        fails++;
        $display("FAIL step%0d outputs: got L=%b W=%b G=%b WHO=%b, expected L=%b W=%b G=%b WHO=%b",
                 e.id, LOSER, WINNER, GAMEOVER, WHO, e.l, e.w, e.g, e.who);
      end
`ifdef GAME_COUNTER_COUNT_OUT_EN
      tests++;
      if (count_o !== e.cnt) begin
        fails++;
        $display("FAIL step%0d count: got %0d, expected %0d", e.id, count_o, e.cnt);
      end
`endif
    end
  end
  task automatic cyc(input logic [1:0] c, input logic i, input logic [3:0] ld,
                     input logic l, input logic w, input logic g, input logic [1:0] who,
                     input logic [3:0] cn);
    ctrl = c;
    INIT = i;
    loadValue = ld;
    @(posedge clk);
    q.push_back('{id, l, w, g, who, cn});
    id++;
    @(negedge clk);
  endtask
  task automatic rst_check();
    q.push_back('{id, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0});
    id++;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
  endtask
  // free run with ctrl=00 from count 0 and cleared tallies: 15th LOSER lands on edge 225,
  // edge 226 is the restart, then the game repeats
  task automatic run_game(input int n);
    for (int k = 1; k <= n; k++) begin
      int         ee = (k - 1) % 226 + 1;
      int         s  = (ee - 1) % 16;
      logic       l, w, g;
      logic [1:0] who;
      logic [3:0] cn;
      if (ee == 226) begin
        l = 0; w = 0; g = 0; who = 2'b00; cn = 4'd0;
      end else begin
        l = (s == 0); w = (s == 15); g = (ee == 225);
        who = g ? 2'b01 : 2'b00;
        cn = 4'((s + 1) % 16);
      end
      cyc(2'b00, 1'b0, 4'd0, l, w, g, who, cn);
    end
  endtask
  initial begin
    ctrl = 2'b00;
    INIT = 1'b0;
    loadValue = 4'd0;
    rst_l = 1'b1;
    #1 rst_l = 1'b0;
    rst_check();
    @(negedge clk) rst_l = 1'b1;
    cyc(2'b00, 1'b1, 4'd13, 0, 0, 0, 2'b00, 4'd13);
    cyc(2'b00, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd14);
    cyc(2'b00, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd15);
    cyc(2'b00, 1'b0, 4'd0,  0, 1, 0, 2'b00, 4'd0);
    cyc(2'b00, 1'b0, 4'd0,  1, 0, 0, 2'b00, 4'd1);
    cyc(2'b00, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd2);
    cyc(2'b00, 1'b1, 4'd4,  0, 0, 0, 2'b00, 4'd4);
    cyc(2'b11, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd2);
    cyc(2'b11, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd0);
    cyc(2'b11, 1'b0, 4'd0,  1, 0, 0, 2'b00, 4'd14);
    cyc(2'b11, 1'b0, 4'd0,  0, 0, 0, 2'b00, 4'd12);
    cyc(2'b00, 1'b1, 4'd15, 0, 0, 0, 2'b00, 4'd15);
    cyc(2'b01, 1'b0, 4'd0,  0, 1, 0, 2'b00, 4'd1);
    cyc(2'b00, 1'b1, 4'd15, 0, 0, 0, 2'b00, 4'd15);
    ctrl = 2'b00;
    INIT = 1'b0;
    @(posedge clk);
    #1 rst_l = 1'b0;
    rst_check();
    @(negedge clk) rst_l = 1'b1;
    run_game(228);
    cyc(2'b00, 1'b1, 4'd0, 0, 0, 0, 2'b00, 4'd0);
    run_game(16);
    cyc(2'b00, 1'b1, 4'd0, 0, 0, 0, 2'b00, 4'd0);
    run_game(228);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
